uart_xfifo: RTL and testbench

UART_XFIFO -- requirements
Module: uart_xfifo

---
 rtl/uart_xfifo_pkg.sv | 45 ++++
 rtl/uart_xfifo_ram.sv | 27 ++
 rtl/uart_xfifo.sv | 145 ++++++++++++++
 tb/tb_uart_xfifo.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_xfifo_pkg.sv
// uart_xfifo_pkg: shared defaults and types for the UART FIFOs.
// Holds default geometry, RX trigger-level encodings and the per-cycle
// FIFO operation decode used by uart_xfifo.
package uart_xfifo_pkg;

    // Default geometry: 8 data bits, 16 entries, 3 error-tag bits
    // (break / framing / parity).
    localparam int UART_WIDTH_DEF = 8;
    localparam int UART_DEPTH_DEF = 16;
    localparam int UART_ERRW_DEF  = 3;

    // 16550-style RX trigger levels, in entries.
    localparam int RX_TRIG_LVL_1  = 1;
    localparam int RX_TRIG_LVL_4  = 4;
    localparam int RX_TRIG_LVL_8  = 8;
    localparam int RX_TRIG_LVL_14 = 14;

    // Two-bit FCR trigger-select encoding.
    typedef enum logic [1:0] {
        RX_TRIG_1  = 2'd0,
        RX_TRIG_4  = 2'd1,
        RX_TRIG_8  = 2'd2,
        RX_TRIG_14 = 2'd3
    } rx_trig_e;

    // What the FIFO does with the current {push,pop} pair.
    typedef enum logic [2:0] {
        OP_IDLE  = 3'd0,
        OP_WRITE = 3'd1,
        OP_DROP  = 3'd2,
        OP_READ  = 3'd3,
        OP_BOTH  = 3'd4
    } fifo_op_e;

    // Map a trigger-select code to its entry count.
    function automatic int trig_level(input rx_trig_e sel);
        case (sel)
            RX_TRIG_1:  return RX_TRIG_LVL_1;
            RX_TRIG_4:  return RX_TRIG_LVL_4;
            RX_TRIG_8:  return RX_TRIG_LVL_8;
            default:    return RX_TRIG_LVL_14;
        endcase
    endfunction

endpackage

// File: rtl/uart_xfifo_ram.sv
// uart_xfifo_ram: storage array for uart_xfifo.
// Synchronous write, asynchronous read; no reset on the contents so it maps
// onto distributed RAM.
module uart_xfifo_ram #(
    parameter int DW = 11,
    parameter int AW = 4
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [DW-1:0] wdata,
    input  logic [AW-1:0] raddr,
    output logic [DW-1:0] rdata
);

    logic [DW-1:0] mem [0:(1<<AW)-1];

    // Write port: store one entry per accepted push.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/uart_xfifo.sv
// uart_xfifo: UART data FIFO with per-entry error tags, first-word
// fall-through head, sticky overrun and 16550-style err_pending.
// Optional macro UART_FIFO_THRESH_EN adds the thresh input and the
// registered thresh_hit output.
module uart_xfifo
    import uart_xfifo_pkg::*;
#(
    parameter  int WIDTH = UART_WIDTH_DEF,
    parameter  int DEPTH = UART_DEPTH_DEF,
    parameter  int ERRW  = UART_ERRW_DEF,
    localparam int PW    = $clog2(DEPTH),
    localparam int CW    = PW + 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             fifo_reset,
    input  logic             reset_status,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic [ERRW-1:0]  din_err,
    input  logic             pop,
`ifdef UART_FIFO_THRESH_EN
    input  logic [CW-1:0]    thresh,
    output logic             thresh_hit,
`endif
    output logic [WIDTH-1:0] dout,
    output logic [ERRW-1:0]  dout_err,
    output logic [CW-1:0]    count,
    output logic             empty,
    output logic             full,
    output logic             overrun,
    output logic             err_pending
);

    logic [PW-1:0]         wptr;
    logic [PW-1:0]         rptr;
    logic [CW-1:0]         count_q;
    logic [CW-1:0]         count_next;
    logic [CW-1:0]         errcnt;
    logic [CW-1:0]         errcnt_next;
    logic                  overrun_q;
    logic                  do_write;
    logic                  do_read;
    logic                  err_in;
    logic                  err_out;
    logic [ERRW+WIDTH-1:0] rd_word;
    fifo_op_e              op;

    assign empty = (count_q == '0);
    assign full  = (count_q == CW'(DEPTH));

    // Decode {push,pop} into one operation; any reset cycle does nothing.
    always_comb begin
        op = OP_IDLE;
        if (!reset && !fifo_reset) begin
            case ({push, pop})
                2'b10:   op = full  ? OP_DROP  : OP_WRITE;
                2'b01:   op = empty ? OP_IDLE  : OP_READ;
                2'b11:   op = empty ? OP_WRITE : OP_BOTH;
                default: op = OP_IDLE;
            endcase
        end
    end

    assign do_write = (op == OP_WRITE) || (op == OP_BOTH);
    assign do_read  = (op == OP_READ)  || (op == OP_BOTH);
    assign err_in   = do_write && (din_err  != '0);
    assign err_out  = do_read  && (dout_err != '0);

    // Next occupancy and next tagged-entry count; both zero on any reset.
    always_comb begin
        count_next  = count_q;
        errcnt_next = errcnt;
        if (reset || fifo_reset) begin
            count_next  = '0;
            errcnt_next = '0;
        end else begin
            if (op == OP_WRITE) begin
                count_next = count_q + CW'(1);
            end else if (op == OP_READ) begin
                count_next = count_q - CW'(1);
            end
            if (err_in && !err_out) begin
                errcnt_next = errcnt + CW'(1);
            end else if (err_out && !err_in) begin
                errcnt_next = errcnt - CW'(1);
            end
        end
    end

    // Pointers, counts and sticky overrun; clear of overrun beats a set.
    always_ff @(posedge clk) begin
        if (reset || fifo_reset) begin
            wptr      <= '0;
            rptr      <= '0;
            count_q   <= '0;
            errcnt    <= '0;
            overrun_q <= 1'b0;
        end else begin
            if (do_write) begin
                wptr <= wptr + PW'(1);
            end
            if (do_read) begin
                rptr <= rptr + PW'(1);
            end
            count_q <= count_next;
            errcnt  <= errcnt_next;
            if (reset_status) begin
                overrun_q <= 1'b0;
            end else if (op == OP_DROP) begin
                overrun_q <= 1'b1;
            end
        end
    end

`ifdef UART_FIFO_THRESH_EN
    // Threshold flag tracks the occupancy being loaded this edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            thresh_hit <= 1'b0;
        end else begin
            thresh_hit <= (thresh != '0) && (count_next >= thresh);
        end
    end
`endif

    uart_xfifo_ram #(
        .DW(ERRW + WIDTH),
        .AW(PW)
    ) u_ram (
        .clk   (clk),
        .we    (do_write),
        .waddr (wptr),
        .wdata ({din_err, din}),
        .raddr (rptr),
        .rdata (rd_word)
    );

    assign dout        = rd_word[WIDTH-1:0];
    assign dout_err    = rd_word[ERRW+WIDTH-1:WIDTH];
    assign count       = count_q;
    assign overrun     = overrun_q;
    assign err_pending = (errcnt != '0);

endmodule

// File: tb/tb_uart_xfifo.sv
// tb_uart_xfifo: directed bench for uart_xfifo with a queue-based model
// checked every cycle, plus literal expectations on the directed steps.
// Define UART_FIFO_THRESH_EN to also exercise thresh/thresh_hit.
module tb_uart_xfifo;

    localparam int WIDTH = 8;
    localparam int DEPTH = 16;
    localparam int ERRW  = 3;
    localparam int CW    = 5;

    typedef struct packed {
        logic [ERRW-1:0]  err;
        logic [WIDTH-1:0] data;
    } entry_t;

    logic             clk = 1'b0;
    logic             reset;
    logic             fifo_reset;
    logic             reset_status;
    logic             push;
    logic             pop;
    logic [WIDTH-1:0] din;
    logic [ERRW-1:0]  din_err;
    logic [WIDTH-1:0] dout;
    logic [ERRW-1:0]  dout_err;
    logic [CW-1:0]    count;
    logic             empty;
    logic             full;
    logic             overrun;
    logic             err_pending;
`ifdef UART_FIFO_THRESH_EN
    logic [CW-1:0]    thresh;
    logic             thresh_hit;
    bit               m_thr = 1'b0;
`endif

    int     checks   = 0;
    int     failures = 0;
    entry_t mq[$];
    bit     m_ovr      = 1'b0;
    bit     model_live = 1'b0;

    always #5 clk = ~clk;

    uart_xfifo #(
        .WIDTH(WIDTH),
        .DEPTH(DEPTH),
        .ERRW(ERRW)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .fifo_reset   (fifo_reset),
        .reset_status (reset_status),
        .push         (push),
        .din          (din),
        .din_err      (din_err),
        .pop          (pop),
`ifdef UART_FIFO_THRESH_EN
        .thresh       (thresh),
        .thresh_hit   (thresh_hit),
`endif
        .dout         (dout),
        .dout_err     (dout_err),
        .count        (count),
        .empty        (empty),
        .full         (full),
        .overrun      (overrun),
        .err_pending  (err_pending)
    );

    task automatic checkOutput(input string name, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            failures++;
            $display("[TB] FAIL %s actual=0x%0h expected=0x%0h t=%0t", name, actual, expected, $time);
        end
    endtask

    // Reference FIFO: a queue that pops the head then appends when room.
    always @(posedge clk) begin
        bit pop_ok;
        bit push_ok;
        if (reset || fifo_reset) begin
            mq.delete();
            m_ovr = 1'b0;
        end else begin
            pop_ok  = pop && (mq.size() > 0);
            push_ok = push && ((mq.size() < DEPTH) || pop_ok);
            if (pop_ok) void'(mq.pop_front());
            if (push_ok) mq.push_back('{err: din_err, data: din});
            if (push && !push_ok) m_ovr = 1'b1;
            if (reset_status) m_ovr = 1'b0;
        end
`ifdef UART_FIFO_THRESH_EN
        m_thr = !reset && (thresh != 0) && (mq.size() >= int'(thresh));
`endif
        model_live = 1'b1;
    end

    // Every cycle, compare all outputs against the reference queue.
    always @(negedge clk) begin
        int n;
        bit ep;
        if (model_live) begin
            n  = mq.size();
            ep = 1'b0;
            foreach (mq[i]) if (mq[i].err != '0) ep = 1'b1;
            checkOutput("model_count", int'(count), n);
            checkOutput("model_empty", int'(empty), int'(n == 0));
            checkOutput("model_full", int'(full), int'(n == DEPTH));
            checkOutput("model_overrun", int'(overrun), int'(m_ovr));
            checkOutput("model_err_pending", int'(err_pending), int'(ep));
            if (n > 0) begin
                checkOutput("model_dout", int'(dout), int'(mq[0].data));
                checkOutput("model_dout_err", int'(dout_err), int'(mq[0].err));
            end
`ifdef UART_FIFO_THRESH_EN
            checkOutput("model_thresh_hit", int'(thresh_hit), int'(m_thr));
`endif
        end
    end

    task automatic applyStimulus(input bit p, input bit q, input logic [WIDTH-1:0] d,
                                 input logic [ERRW-1:0] e, input bit fr = 1'b0,
                                 input bit rs = 1'b0, input bit rst = 1'b0);
        @(negedge clk);
        #1;
        push = p; pop = q; din = d; din_err = e;
        fifo_reset = fr; reset_status = rs; reset = rst;
        @(posedge clk);
        #2;
        push = 1'b0; pop = 1'b0; fifo_reset = 1'b0; reset_status = 1'b0; reset = 1'b0;
    endtask

    initial begin
        reset = 1'b1; fifo_reset = 1'b0; reset_status = 1'b0;
        push = 1'b0; pop = 1'b0; din = '0; din_err = '0;
`ifdef UART_FIFO_THRESH_EN
        thresh = '0;
`endif
        repeat (2) @(posedge clk);
        #2;
        reset = 1'b0;

        // Reset state
        checkOutput("rst_count", int'(count), 0);
        checkOutput("rst_empty", int'(empty), 1);
        checkOutput("rst_full", int'(full), 0);
        checkOutput("rst_overrun", int'(overrun), 0);
        checkOutput("rst_err_pending", int'(err_pending), 0);

        // Single push then pop
        applyStimulus(1, 0, 8'hA5, 0);
        checkOutput("a5_dout", int'(dout), 'hA5);
        checkOutput("a5_count", int'(count), 1);
        checkOutput("a5_empty", int'(empty), 0);
        applyStimulus(0, 1, 8'h00, 0);
        checkOutput("a5_pop_count", int'(count), 0);
        checkOutput("a5_pop_empty", int'(empty), 1);

        // Fill, overflow, clear status
        for (int i = 0; i < 16; i++) applyStimulus(1, 0, 8'(8'h10 + i), 0);
        checkOutput("fill_full", int'(full), 1);
        applyStimulus(1, 0, 8'hEE, 0);
        checkOutput("ovf_count", int'(count), 16);
        checkOutput("ovf_overrun", int'(overrun), 1);
        checkOutput("ovf_head", int'(dout), 'h10);
        applyStimulus(0, 0, 8'h00, 0, 0, 1);
        checkOutput("rs_overrun", int'(overrun), 0);

        // Push+pop while full keeps count and order
        applyStimulus(1, 1, 8'h55, 0);
        checkOutput("pp_full_count", int'(count), 16);
        checkOutput("pp_full_head", int'(dout), 'h11);
        checkOutput("pp_full_overrun", int'(overrun), 0);
        for (int i = 0; i < 16; i++) begin
            checkOutput("drain_order", int'(dout), (i < 15) ? ('h11 + i) : 'h55);
            applyStimulus(0, 1, 8'h00, 0);
        end
        checkOutput("drain_empty", int'(empty), 1);

        // Push+pop while empty writes only
        applyStimulus(1, 1, 8'h77, 0);
        checkOutput("pp_empty_count", int'(count), 1);
        checkOutput("pp_empty_dout", int'(dout), 'h77);
        applyStimulus(0, 1, 8'h00, 0);

        // 40 streaming cycles wrap both pointers
        for (int i = 0; i < 40; i++) begin
            applyStimulus(1, i > 0, 8'(i), 0);
            checkOutput("wrap_dout", int'(dout), i);
            checkOutput("wrap_count", int'(count), 1);
        end
        applyStimulus(0, 1, 8'h00, 0);

        // Error tags and err_pending
        applyStimulus(1, 0, 8'h01, 3'd0);
        checkOutput("tag0_pending", int'(err_pending), 0);
        applyStimulus(1, 0, 8'h02, 3'd4);
        checkOutput("tag4_pending", int'(err_pending), 1);
        applyStimulus(1, 0, 8'h03, 3'd0);
        checkOutput("tag0b_pending", int'(err_pending), 1);
        applyStimulus(0, 1, 8'h00, 0);
        checkOutput("pop1_pending", int'(err_pending), 1);
        checkOutput("pop1_dout_err", int'(dout_err), 4);
        applyStimulus(0, 1, 8'h00, 0);
        checkOutput("pop2_pending", int'(err_pending), 0);
        checkOutput("pop2_dout", int'(dout), 'h03);
        applyStimulus(0, 1, 8'h00, 0);

        // fifo_reset mid-stream discards coincident push/pop and clears flags
        applyStimulus(1, 0, 8'h30, 3'd2);
        applyStimulus(1, 0, 8'h31, 3'd1);
        for (int i = 0; i < 14; i++) applyStimulus(1, 0, 8'(8'h32 + i), 0);
        applyStimulus(1, 0, 8'hEF, 0);
        checkOutput("pre_fr_overrun", int'(overrun), 1);
        applyStimulus(1, 1, 8'h99, 3'd5, 1);
        checkOutput("fr_count", int'(count), 0);
        checkOutput("fr_pending", int'(err_pending), 0);
        checkOutput("fr_overrun", int'(overrun), 0);

        // Overrun set and clear in the same cycle resolves to clear
        for (int i = 0; i < 16; i++) applyStimulus(1, 0, 8'(8'h40 + i), 0);
        applyStimulus(1, 0, 8'hDD, 0, 0, 1);
        checkOutput("setclr_overrun", int'(overrun), 0);
        checkOutput("setclr_head", int'(dout), 'h40);
        applyStimulus(0, 0, 8'h00, 0, 1);

        // Block reset abandons a coincident push/pop
        applyStimulus(1, 0, 8'h61, 3'd1);
        applyStimulus(1, 0, 8'h62, 0);
        applyStimulus(1, 1, 8'h88, 3'd1, 0, 0, 1);
        checkOutput("rstmid_count", int'(count), 0);
        checkOutput("rstmid_pending", int'(err_pending), 0);
        applyStimulus(1, 0, 8'h66, 0);
        checkOutput("rstmid_dout", int'(dout), 'h66);
        applyStimulus(0, 1, 8'h00, 0);

`ifdef UART_FIFO_THRESH_EN
        // Threshold flag at 8 entries
        thresh = CW'(8);
        for (int i = 0; i < 7; i++) applyStimulus(1, 0, 8'(i), 0);
        checkOutput("thr7_hit", int'(thresh_hit), 0);
        applyStimulus(1, 0, 8'h07, 0);
        checkOutput("thr8_hit", int'(thresh_hit), 1);
        applyStimulus(0, 1, 8'h00, 0);
        checkOutput("thr_pop_hit", int'(thresh_hit), 0);
        thresh = '0;
        applyStimulus(1, 0, 8'h08, 0);
        checkOutput("thr_zero_hit", int'(thresh_hit), 0);
`endif

        @(negedge clk);
        #1;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
